// File: rtl/clock_enable_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// clken_pkg
// Shared definitions for the clock-enable scheduler:
//   CLKEN_DIV_W      default width of a channel period field
//   clken_div_t      period / counter value at the default width
//   clken_ch_state_t one channel's state {div, cnt, pend, pdiv}
//   clken_ch_w()     width of a channel index for a given channel count
// Optional feature macro used by the other files: CLKEN_SYNC_EN.
// ---------------------------------------------------------------------------
package clken_pkg;

    localparam int CLKEN_DIV_W = 8;

    typedef logic [CLKEN_DIV_W-1:0] clken_div_t;

    typedef struct packed {
        clken_div_t div;
        clken_div_t cnt;
        logic       pend;
        clken_div_t pdiv;
    } clken_ch_state_t;

    // A single-channel build still needs a one-bit index field.
    function automatic int clken_ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/clock_enable_scheduler_if.sv
// ---------------------------------------------------------------------------
// clock_enable_scheduler_if
// Configuration port of the clock-enable scheduler (valid/ready handshake).
//   valid  request: write div into channel ch
//   ready  accept; low while the addressed channel still holds an update
//   ch     target channel index
//   div    new period (0 disables the channel)
// Modports: master (requester), slave (scheduler).
// ---------------------------------------------------------------------------
interface clock_enable_scheduler_if
    import clken_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = CLKEN_DIV_W
);
    localparam int CH_W = clken_ch_w(NUM_CH);

    logic             valid;
    logic             ready;
    logic [CH_W-1:0]  ch;
    logic [DIV_W-1:0] div;

    modport master (
        output valid,
        output ch,
        output div,
        input  ready
    );

    modport slave (
        input  valid,
        input  ch,
        input  div,
        output ready
    );

endinterface

// File: rtl/clock_enable_scheduler_channel.sv
// ---------------------------------------------------------------------------
// clken_channel
// One scheduler channel: period register, down-counter, one-deep pending
// update and the registered enable pulse.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   run          0 freezes the counter and suppresses pulses
//   sync         (only with CLKEN_SYNC_EN) zero the counter, apply pending
//   accept       config write accepted for this channel this cycle
//   cfg_div      period carried by that write
//   ce           registered one-cycle enable pulse
//   pend         update accepted but not yet applied
// ---------------------------------------------------------------------------
module clken_channel #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
`ifdef CLKEN_SYNC_EN
    input  logic             sync,
`endif
    input  logic             accept,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             ce,
    output logic             pend
);

    logic [DIV_W-1:0] div_reg,  div_next;
    logic [DIV_W-1:0] cnt_reg,  cnt_next;
    logic [DIV_W-1:0] pdiv_reg, pdiv_next;
    logic             pend_reg, pend_next;
    logic             ce_reg,   ce_next;

    logic active;
    logic wrap;

    assign active = run && (div_reg != '0);
    assign wrap   = active && (cnt_reg == '0);

    always_comb begin
        div_next  = div_reg;
        cnt_next  = cnt_reg;
        pdiv_next = pdiv_reg;
        pend_next = pend_reg;
        ce_next   = 1'b0;

`ifdef CLKEN_SYNC_EN
        // Alignment outranks the wrap: no pulse this edge, every channel
        // restarts from zero so they all fire together on the next edge.
        if (sync) begin
            cnt_next = '0;
            if (pend_reg) begin
                div_next  = pdiv_reg;
                pend_next = 1'b0;
            end
        end else
`endif
        if (wrap) begin
            // The pulse for this wrap goes out even when the period changes.
            ce_next = 1'b1;
            if (pend_reg) begin
                div_next  = pdiv_reg;
                pend_next = 1'b0;
                // A zero period stops the channel; avoid the wrapped 0-1.
                cnt_next  = (pdiv_reg == '0) ? '0 : pdiv_reg - DIV_W'(1);
            end else begin
                cnt_next  = div_reg - DIV_W'(1);
            end
        end else if (pend_reg && !active) begin
            // Idle channel: nothing in flight to protect, apply right away.
            div_next  = pdiv_reg;
            cnt_next  = '0;
            pend_next = 1'b0;
        end else if (active) begin
            cnt_next = cnt_reg - DIV_W'(1);
        end

        // The top only accepts while pend_reg is clear, so this never
        // collides with an apply in the same cycle.
        if (accept) begin
            pdiv_next = cfg_div;
            pend_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg  <= '0;
            cnt_reg  <= '0;
            pdiv_reg <= '0;
            pend_reg <= 1'b0;
            ce_reg   <= 1'b0;
        end else begin
            div_reg  <= div_next;
            cnt_reg  <= cnt_next;
            pdiv_reg <= pdiv_next;
            pend_reg <= pend_next;
            ce_reg   <= ce_next;
        end
    end

    assign ce   = ce_reg;
    assign pend = pend_reg;

endmodule

// File: rtl/clock_enable_scheduler.sv
// ---------------------------------------------------------------------------
// clock_enable_scheduler
// Multi-channel clock-enable generator: each channel emits one-cycle enable
// pulses on the main clock with a programmable period. Period changes take
// effect at a period boundary so consumers never see runt or double pulses.
// Ports:
//   clk, reset   sole clock, synchronous active-high reset
//   run          global run; 0 freezes every channel counter
//   sync_start   alignment pulse (present only when CLKEN_SYNC_EN is defined)
//   cfg          configuration port (clock_enable_scheduler_if.slave)
//   ce           registered enable pulses, one bit per channel
//   pend         per-channel "update accepted, not yet applied"
// Optional feature macro: CLKEN_SYNC_EN.
// ---------------------------------------------------------------------------
module clock_enable_scheduler
    import clken_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = CLKEN_DIV_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
`ifdef CLKEN_SYNC_EN
    input  logic                     sync_start,
`endif
    clock_enable_scheduler_if.slave  cfg,
    output logic [NUM_CH-1:0]        ce,
    output logic [NUM_CH-1:0]        pend
);

    localparam int CH_W = clken_ch_w(NUM_CH);

    logic              ready;
    logic [NUM_CH-1:0] accept;

    // Ready mirrors the addressed channel's pending flag; an index beyond
    // NUM_CH is never ready so the write stalls instead of vanishing.
    always_comb begin
        ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg.ch == CH_W'(i)) begin
                ready = ~pend[i];
            end
        end
    end

    assign cfg.ready = ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign accept[gi] = cfg.valid && ready && (cfg.ch == CH_W'(gi));

            clken_channel #(
                .DIV_W   (DIV_W)
            ) u_channel (
                .clk     (clk),
                .reset   (reset),
                .run     (run),
`ifdef CLKEN_SYNC_EN
                .sync    (sync_start),
`endif
                .accept  (accept[gi]),
                .cfg_div (cfg.div),
                .ce      (ce[gi]),
                .pend    (pend[gi])
            );
        end
    endgenerate

endmodule
